pipe_ctrl: RTL
==============

# pipe_ctrl

- Central pipeline control for the 5-stage MIPS core.
- Drives the `en` and `clr` inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register enable.
- Resolves, in fixed priority:
  - halt freeze
  - multi-cycle mul/div stall (counter-timed)
  - taken-branch flush
  - load-use bubble
- Sits directly upstream of every pipeline register instance; the pipeline registers only consume these signals.

## Interface
Parameters:
- MD_LAT, 4 — total stall cycles inserted per mul/div instruction (legal range 1..15).
- CW, 4 — width of the mul/div wait counter.

Ports:
- clk  in  1  — core clock; all state updates on rising edge.
- clr_n  in  1  — asynchronous, active-low reset.
- halt  in  1  — syscall-halt decoded in EX.
- ex_md_start  in  1  — instruction in EX is mul/div.
- ex_br_taken  in  1  — branch/jump in EX resolved taken.
- ex_memread  in  1  — instruction in EX is a load.
- ex_rd  in  5  — destination register of the EX instruction.
- id_rs, id_rt  in  5 each  — source registers of the ID instruction.
- id_use_rs, id_use_rt  in  1 each  — ID instruction actually reads rs/rt.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  — register enables.
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  — register clears.
- md_busy  out  1  — mul/div stall active this cycle.
- halted  out  1  — core frozen.
- stall_cycles, flush_count  out  32 each  — statistics (see Configuration).

## Operation
FSM states: RUN, MDWAIT, HALTED. Reset state: RUN, counter 0.

While clr_n=0:
- all en=0, all clr=1, md_busy=0, halted=0, statistics 0.

Default outputs when released and nothing applies: all en=1, all clr=0.

RUN, in priority order:
1. halt=1 → all en=0, all clr=0; next state HALTED.
2. ex_md_start=1 → stall:
   - pc_en=ifid_en=idex_en=0, exmem_clr=1 (bubble into MEM); md_busy=1.
   - Next state MDWAIT, cnt←MD_LAT-1.
3. ex_br_taken=1 → ifid_clr=1, idex_clr=1, pc_en=1 (flush two wrong-path instructions).
4. Load-use → pc_en=0, ifid_en=0, idex_clr=1 (one bubble).
   - Load-use condition: ex_memread & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).

MDWAIT:
- halt=1 → HALTED; same freeze as RUN rule 1.
- cnt≠0 → same stall outputs as RUN rule 2; cnt←cnt-1.
- cnt==0 → no md stall. Rules 3–4 evaluated as in RUN; ex_md_start is ignored this cycle (the same instruction leaves EX at this edge). Next state RUN.

HALTED:
- All en=0, clr=0; halted=1.
- Exits only via clr_n.

## Timing
- All outputs are combinational from state plus current inputs. There is no output register, so zero-cycle response to hazards.
- Mul/div: EX occupancy is MD_LAT+1 cycles; md_busy is high for exactly MD_LAT consecutive cycles. With MD_LAT=1, MDWAIT is entered with cnt=0 and releases immediately.
- Load-use costs 1 cycle; taken branch costs 2 cycles.
- Reset asserted mid-MDWAIT → RUN, cnt=0 immediately (asynchronous); no residual stall after release.
- halt coincident with ex_md_start or ex_br_taken → halt wins; no flush/bubble is applied.
- ex_rd=0 never triggers load-use.

## Configuration
- STALL_STAT_EN defined:
  - stall_cycles increments on every cycle with pc_en=0 in RUN/MDWAIT (not HALTED).
  - flush_count increments on every applied branch flush.
  - Both wrap modulo 2^32 and reset to 0.
- STALL_STAT_EN undefined: both outputs tied to 0; no counters synthesized.

## Test plan
- Reset then idle inputs → all en=1, clr=0. During clr_n=0 → all en=0, all clr=1.
- ex_memread=1, ex_rd=8, id_rs=8, id_use_rs=1 for 1 cycle → pc_en=ifid_en=0 and idex_clr=1 for that cycle only. Repeat with ex_rd=0 → no stall.
- ex_md_start held high while stalled, MD_LAT=4:
  - md_busy high exactly 4 cycles, exmem_clr high those 4 cycles.
  - 5th cycle releases; no restart.
  - With STALL_STAT_EN, stall_cycles=4.
- ex_br_taken=1 together with a load-use match → only flush (ifid_clr=idex_clr=1, pc_en=1); flush_count=1.
- clr_n pulsed low on the 2nd MDWAIT cycle → after release: state RUN, no stall with inputs idle, counters 0.
- halt=1 while in MDWAIT → all en=0 from that cycle; halted=1 persists with halt deasserted until clr_n.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the hazard/stall controller and the datapath.
// slave = controller side, master = datapath side.
interface pipe_ctrl_if;
  logic        halt;
  logic        ex_md_start;
  logic        ex_br_taken;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_clr;
  logic        idex_clr;
  logic        exmem_clr;
  logic        memwb_clr;
  logic        md_busy;
  logic        halted;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output halt, ex_md_start, ex_br_taken, ex_memread, ex_rd,
           id_rs, id_rt, id_use_rs, id_use_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, memwb_clr,
           md_busy, halted, stall_cycles, flush_count
  );

  modport slave (
    input  halt, ex_md_start, ex_br_taken, ex_memread, ex_rd,
           id_rs, id_rt, id_use_rs, id_use_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, memwb_clr,
           md_busy, halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline control: halt freeze > mul/div stall > branch flush > load-use bubble.
// Optional statistics counters enabled by defining STALL_STAT_EN.
module pipe_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CW     = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  pipe_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {RUN, MDWAIT, HALTED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic md_busy, halted, flush_c, load_use_c;

  assign load_use_c = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                       (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and combinational control outputs; reset overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    md_busy   = 1'b0;
    halted    = 1'b0;
    flush_c   = 1'b0;

    unique case (state_q)
      RUN, MDWAIT: begin
        if (bus.halt) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          state_d = HALTED;
        end else if ((state_q == MDWAIT && cnt_q != '0) ||
                     (state_q == RUN && bus.ex_md_start)) begin
          {pc_en, ifid_en, idex_en} = 3'b000;
          exmem_clr = 1'b1;
          md_busy   = 1'b1;
          state_d   = MDWAIT;
          cnt_d     = (state_q == RUN) ? CW'(MD_LAT - 1) : cnt_q - CW'(1);
        end else begin
          // Plain RUN, or the release cycle of a mul/div where ex_md_start is ignored.
          state_d = RUN;
          if (bus.ex_br_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            flush_c  = 1'b1;
          end else if (load_use_c) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end
        end
      end
      HALTED: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        halted = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (!clr_n) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en}   = 5'b00000;
      {ifid_clr, idex_clr, exmem_clr, memwb_clr}      = 4'b1111;
      md_busy = 1'b0;
      halted  = 1'b0;
      flush_c = 1'b0;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.ifid_en   = ifid_en;
  assign bus.idex_en   = idex_en;
  assign bus.exmem_en  = exmem_en;
  assign bus.memwb_en  = memwb_en;
  assign bus.ifid_clr  = ifid_clr;
  assign bus.idex_clr  = idex_clr;
  assign bus.exmem_clr = exmem_clr;
  assign bus.memwb_clr = memwb_clr;
  assign bus.md_busy   = md_busy;
  assign bus.halted    = halted;

`ifdef STALL_STAT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state_q != HALTED && !pc_en) stall_q <= stall_q + 32'd1;
      if (flush_c)                     flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif

endmodule
